// File: rtl/kf6845_pkg.sv
// Shared types and constants for the KF6845 refresh-address / cursor slice.
//   MA_WIDTH            : refresh memory address width (14)
//   RA_WIDTH            : raster address width (5)
//   ma_t                : refresh memory address type
//   cursor_blink_mode_t : R10[6:5] cursor blink mode encoding
//   cursor_blink_on     : blink decode from mode and field counter
package kf6845_pkg;

    localparam int MA_WIDTH = 14;
    localparam int RA_WIDTH = 5;

    typedef logic [MA_WIDTH-1:0] ma_t;

    typedef enum logic [1:0] {
        STEADY  = 2'b00,
        OFF     = 2'b01,
        BLINK16 = 2'b10,
        BLINK32 = 2'b11
    } cursor_blink_mode_t;

    // BLINK16 toggles every 8 fields (16-field period); BLINK32 every 16.
    function automatic logic cursor_blink_on(input cursor_blink_mode_t mode,
                                             input logic [4:0] field_count);
        logic on;
        case (mode)
            STEADY:  on = 1'b1;
            OFF:     on = 1'b0;
            BLINK16: on = ~field_count[3];
            BLINK32: on = ~field_count[4];
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/kf6845_refresh_address_if.sv
// Signal bundle between the CRTC control blocks and the refresh-address block.
//   master : drives register writes and timing strobes, observes MA/DISPTMG/CURSOR
//   slave  : the refresh-address block itself
// Timing strobes (Horizontal, V_total, Scanline_End) are single-cycle pulses
// sampled on the clock edge; V_total and Scanline_End arrive already qualified.
interface kf6845_refresh_address_if;
    import kf6845_pkg::*;

    logic                video_clock_enable;
    logic [7:0]          internal_data_bus;
    logic                write_horizontal_displayed_register;
    logic                write_cursor_start_register;
    logic                write_cursor_end_register;
    logic                write_start_address_h_register;
    logic                write_start_address_l_register;
    logic                write_cursor_h_register;
    logic                write_cursor_l_register;
    logic                Horizontal;
    logic                H_Display;
    logic                V_total;
    logic                Scanline_End;
    logic                V_Display;
    logic [RA_WIDTH-1:0] RA;
    ma_t                 MA;
    logic                DISPTMG;
    logic                CURSOR;

    modport master (
        output video_clock_enable, internal_data_bus,
        output write_horizontal_displayed_register, write_cursor_start_register,
        output write_cursor_end_register, write_start_address_h_register,
        output write_start_address_l_register, write_cursor_h_register,
        output write_cursor_l_register,
        output Horizontal, H_Display, V_total, Scanline_End, V_Display, RA,
        input  MA, DISPTMG, CURSOR
    );

    modport slave (
        input  video_clock_enable, internal_data_bus,
        input  write_horizontal_displayed_register, write_cursor_start_register,
        input  write_cursor_end_register, write_start_address_h_register,
        input  write_start_address_l_register, write_cursor_h_register,
        input  write_cursor_l_register,
        input  Horizontal, H_Display, V_total, Scanline_End, V_Display, RA,
        output MA, DISPTMG, CURSOR
    );

endinterface

// File: rtl/kf6845_cursor_control.sv
// Cursor generation: holds R10 (blink mode + start raster), R11 (end raster),
// R14/R15 (cursor address), the 5-bit field counter used for blinking, and
// the combinational cursor compare.
//   clock, reset            : clock, synchronous active-high reset
//   video_clock_enable      : character-clock enable (gates the field counter)
//   internal_data_bus       : register write data
//   write_cursor_*_register : register write strobes (R10, R11, R14, R15)
//   v_total                 : end-of-field strobe
//   h_display, v_display    : display windows
//   ra                      : current raster address
//   ma                      : current (registered) refresh address
//   cursor                  : cursor enable output
module kf6845_cursor_control
    import kf6845_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                video_clock_enable,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_cursor_start_register,
    input  logic                write_cursor_end_register,
    input  logic                write_cursor_h_register,
    input  logic                write_cursor_l_register,
    input  logic                v_total,
    input  logic                h_display,
    input  logic                v_display,
    input  logic [RA_WIDTH-1:0] ra,
    input  ma_t                 ma,
    output logic                cursor
);

    logic [6:0] r10_q, r10_d;
    logic [4:0] r11_q, r11_d;
    logic [5:0] r14_q, r14_d;
    logic [7:0] r15_q, r15_d;
    logic [4:0] field_q, field_d;

    cursor_blink_mode_t blink_mode;
    logic               blink_on;
    logic               in_window;
    logic               addr_match;

    always_comb begin
        r10_d   = r10_q;
        r11_d   = r11_q;
        r14_d   = r14_q;
        r15_d   = r15_q;
        field_d = field_q;
        if (write_cursor_start_register) r10_d = internal_data_bus[6:0];
        if (write_cursor_end_register)   r11_d = internal_data_bus[4:0];
        if (write_cursor_h_register)     r14_d = internal_data_bus[5:0];
        if (write_cursor_l_register)     r15_d = internal_data_bus;
        // Natural 5-bit wrap 31 -> 0.
        if (video_clock_enable && v_total) field_d = field_q + 5'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r10_q   <= '0;
            r11_q   <= '0;
            r14_q   <= '0;
            r15_q   <= '0;
            field_q <= '0;
        end else begin
            r10_q   <= r10_d;
            r11_q   <= r11_d;
            r14_q   <= r14_d;
            r15_q   <= r15_d;
            field_q <= field_d;
        end
    end

    always_comb begin
        blink_mode = cursor_blink_mode_t'(r10_q[6:5]);
        blink_on   = cursor_blink_on(blink_mode, field_q);
        // An inverted window (start > end) can never satisfy both bounds.
        in_window  = (r10_q[4:0] <= ra) && (ra <= r11_q);
        addr_match = (ma == {r14_q, r15_q});
        cursor     = blink_on & h_display & v_display & addr_match & in_window;
    end

endmodule

// File: rtl/kf6845_refresh_address.sv
// Refresh memory address generator for the KF6845 CRTC.
// Holds R1 (characters per row), R12/R13 (start address), the row_start
// register and the MA counter; instantiates the cursor sub-block.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : register writes, timing strobes, RA in; MA, DISPTMG, CURSOR out
module kf6845_refresh_address
    import kf6845_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    kf6845_refresh_address_if.slave bus
);

    logic [7:0] r1_q, r1_d;
    logic [5:0] r12_q, r12_d;
    logic [7:0] r13_q, r13_d;
    ma_t        row_start_q, row_start_d;
    ma_t        ma_q, ma_d;

    ma_t start_addr;
    ma_t next_row;

    always_comb begin
        r1_d  = r1_q;
        r12_d = r12_q;
        r13_d = r13_q;
        if (bus.write_horizontal_displayed_register) r1_d  = bus.internal_data_bus;
        if (bus.write_start_address_h_register)      r12_d = bus.internal_data_bus[5:0];
        if (bus.write_start_address_l_register)      r13_d = bus.internal_data_bus;
    end

    always_comb begin
        // Start address is taken from the registers only at V_total, so
        // writes during a field do not disturb it.
        start_addr  = {r12_q, r13_q};
        next_row    = row_start_q + ma_t'(r1_q);
        ma_d        = ma_q;
        row_start_d = row_start_q;
        if (bus.video_clock_enable) begin
            if (bus.V_total) begin
                ma_d        = start_addr;
                row_start_d = start_addr;
            end else if (bus.Scanline_End) begin
                ma_d        = next_row;
                row_start_d = next_row;
            end else if (bus.Horizontal) begin
                // Replay the same character row on the next raster line.
                ma_d = row_start_q;
            end else begin
                ma_d = ma_q + ma_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r1_q        <= '0;
            r12_q       <= '0;
            r13_q       <= '0;
            row_start_q <= '0;
            ma_q        <= '0;
        end else begin
            r1_q        <= r1_d;
            r12_q       <= r12_d;
            r13_q       <= r13_d;
            row_start_q <= row_start_d;
            ma_q        <= ma_d;
        end
    end

    assign bus.MA      = ma_q;
    assign bus.DISPTMG = bus.H_Display & bus.V_Display;

    kf6845_cursor_control u_cursor (
        .clock                       (clock),
        .reset                       (reset),
        .video_clock_enable          (bus.video_clock_enable),
        .internal_data_bus           (bus.internal_data_bus),
        .write_cursor_start_register (bus.write_cursor_start_register),
        .write_cursor_end_register   (bus.write_cursor_end_register),
        .write_cursor_h_register     (bus.write_cursor_h_register),
        .write_cursor_l_register     (bus.write_cursor_l_register),
        .v_total                     (bus.V_total),
        .h_display                   (bus.H_Display),
        .v_display                   (bus.V_Display),
        .ra                          (bus.RA),
        .ma                          (ma_q),
        .cursor                      (bus.CURSOR)
    );

endmodule
